// File: rtl/hazard_stall_ctrl_if.sv
// rtl/hazard_stall_ctrl_if.sv - pipeline-side signal bundle for the hazard/stall sequencer
interface hazard_stall_ctrl_if #(
  parameter int CNT_W = 32
);
  // ID-stage instruction
  logic [4:0]       if_id_rs;
  logic [4:0]       if_id_rt;
  logic             id_uses_rs;
  logic             id_uses_rt;
  logic             id_is_branch;
  logic             branch_taken;
  // EX-stage instruction
  logic             id_ex_RegWrite;
  logic             id_ex_MemRead;
  logic [4:0]       id_ex_rd;
  // MEM-stage instruction
  logic             ex_mem_MemRead;
  logic [4:0]       ex_mem_rd;
  // multi-cycle unit handshake
  logic             ex_is_mc;
  logic             mc_done;
  logic             mc_start;
  // pipeline controls
  logic             pc_write;
  logic             if_id_write;
  logic             id_ex_bubble;
  logic             if_id_flush;
  logic             ex_freeze;
  // status
  logic [CNT_W-1:0] stall_cnt;
  logic             mc_timeout;

  // pipeline side: presents stage info, consumes controls
  modport master (
    output if_id_rs, if_id_rt, id_uses_rs, id_uses_rt, id_is_branch, branch_taken,
    output id_ex_RegWrite, id_ex_MemRead, id_ex_rd, ex_mem_MemRead, ex_mem_rd,
    output ex_is_mc, mc_done,
    input  mc_start, pc_write, if_id_write, id_ex_bubble, if_id_flush, ex_freeze,
    input  stall_cnt, mc_timeout
  );

  // controller side
  modport slave (
    input  if_id_rs, if_id_rt, id_uses_rs, id_uses_rt, id_is_branch, branch_taken,
    input  id_ex_RegWrite, id_ex_MemRead, id_ex_rd, ex_mem_MemRead, ex_mem_rd,
    input  ex_is_mc, mc_done,
    output mc_start, pc_write, if_id_write, id_ex_bubble, if_id_flush, ex_freeze,
    output stall_cnt, mc_timeout
  );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// rtl/hazard_stall_ctrl.sv - hazard stall/flush sequencer with multi-cycle EX freeze
module hazard_stall_ctrl #(
  parameter int CNT_W      = 32,
  parameter int MC_TIMEOUT = 1024
) (
  input  logic                 clk,
  input  logic                 rst_n,
  hazard_stall_ctrl_if.slave   bus
);

  localparam int              WAIT_W    = $clog2(MC_TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MC_TIMEOUT - 1);
  localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

  localparam logic [0:0] S_RUN     = 1'b0;
  localparam logic [0:0] S_MC_WAIT = 1'b1;

  logic [0:0]        state_q,      state_d;
  logic [WAIT_W-1:0] wait_cnt_q,   wait_cnt_d;
  logic [CNT_W-1:0]  stall_cnt_q,  stall_cnt_d;
  logic              mc_timeout_q, mc_timeout_d;

  logic pc_write, if_id_write, id_ex_bubble, if_id_flush, ex_freeze, mc_start;
  logic lu_hz, bex_hz, bmem_hz, hz, run_rules;

  // a nonzero destination that the ID instruction actually reads
  function automatic logic match(input logic [4:0] r, input logic [4:0] rs, input logic [4:0] rt,
                                 input logic use_rs, input logic use_rt);
    return (r != 5'd0) && (((r == rs) && use_rs) || ((r == rt) && use_rt));
  endfunction

  // hazards the forwarding unit cannot cover: load-use, and branch operands still in flight
  always_comb begin
    lu_hz   = bus.id_ex_MemRead &&
              match(bus.id_ex_rd, bus.if_id_rs, bus.if_id_rt, bus.id_uses_rs, bus.id_uses_rt);
    bex_hz  = bus.id_is_branch && bus.id_ex_RegWrite &&
              match(bus.id_ex_rd, bus.if_id_rs, bus.if_id_rt, bus.id_uses_rs, bus.id_uses_rt);
    bmem_hz = bus.id_is_branch && bus.ex_mem_MemRead &&
              match(bus.ex_mem_rd, bus.if_id_rs, bus.if_id_rt, bus.id_uses_rs, bus.id_uses_rt);
    hz      = lu_hz || bex_hz || bmem_hz;
  end

  // FSM and pipeline controls: freeze beats hazard stall beats branch flush
  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    mc_timeout_d = mc_timeout_q;
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    id_ex_bubble = 1'b0;
    if_id_flush  = 1'b0;
    ex_freeze    = 1'b0;
    mc_start     = 1'b0;
    run_rules    = 1'b0;

    if (state_q == S_RUN) begin
      if (bus.ex_is_mc) begin
        mc_start   = 1'b1;
        ex_freeze  = 1'b1;
        state_d    = S_MC_WAIT;
        wait_cnt_d = '0;
      end else begin
        run_rules = 1'b1;
      end
    end else begin
      if (bus.mc_done) begin
        run_rules  = 1'b1;
        state_d    = S_RUN;
        wait_cnt_d = '0;
      end else if (wait_cnt_q == WAIT_LAST) begin
        mc_timeout_d = 1'b1;
        run_rules    = 1'b1;
        state_d      = S_RUN;
        wait_cnt_d   = '0;
      end else begin
        ex_freeze  = 1'b1;
        wait_cnt_d = wait_cnt_q + WAIT_ONE;
      end
    end

    if (ex_freeze) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
    end else if (run_rules) begin
      if (hz) begin
        pc_write     = 1'b0;
        if_id_write  = 1'b0;
        id_ex_bubble = 1'b1;
      end else begin
        if_id_flush = bus.id_is_branch && bus.branch_taken;
      end
    end
  end

  // count every cycle the PC is held, sticking at all-ones
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!pc_write && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_ONE;
    end
  end

  // state registers; reset mid-wait simply drops the outstanding op
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_RUN;
      wait_cnt_q   <= '0;
      stall_cnt_q  <= '0;
      mc_timeout_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      stall_cnt_q  <= stall_cnt_d;
      mc_timeout_q <= mc_timeout_d;
    end
  end

  assign bus.pc_write     = pc_write;
  assign bus.if_id_write  = if_id_write;
  assign bus.id_ex_bubble = id_ex_bubble;
  assign bus.if_id_flush  = if_id_flush;
  assign bus.ex_freeze    = ex_freeze;
  assign bus.mc_start     = mc_start;
  assign bus.stall_cnt    = stall_cnt_q;
  assign bus.mc_timeout   = mc_timeout_q;

endmodule
